// File: rtl/signal_debounce.sv
// Purpose: synchronize one raw asynchronous input and accept a new level only after it holds for STABLE_CYCLES edges; emits rise/fall pulses.
// Latency: a clean change reaches level and the pulse STABLE_CYCLES+1 edges after the first edge that samples it.
// Backpressure: none. The input is sampled every cycle, and the pulses are single-cycle strobes that consumers must catch.
`timescale 1ns/1ps
module signal_debounce #(
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_W         = 5,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] count;

    // count == 0 is the STABLE state and any nonzero count is COUNT, so no separate state register is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0 <= RESET_LEVEL;
            sync1 <= RESET_LEVEL;
            level <= RESET_LEVEL;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync0 <= signal;
            sync1 <= sync0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync1 != level) begin
                if (count == LAST) begin
                    level <= sync1;
                    count <= '0;
                    rise  <= sync1;
                    fall  <= ~sync1;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                // A return to the current level discards the partial count.
                count <= '0;
            end
        end
    end

    assign busy = (count != '0);

endmodule

// File: tb/tb_signal_debounce.sv
// Directed bench for signal_debounce: default, STABLE_CYCLES=1 and RESET_LEVEL=1 instances.
`timescale 1ns/1ps
module tb_signal_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic reset_a, sig_a, level_a, rise_a, fall_a, busy_a;
    logic reset_b, sig_b, level_b, rise_b, fall_b, busy_b;
    logic reset_c, sig_c, level_c, rise_c, fall_c, busy_c;

    signal_debounce #(.STABLE_CYCLES(16), .CNT_W(5), .RESET_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset_a), .signal(sig_a),
        .level(level_a), .rise(rise_a), .fall(fall_a), .busy(busy_a));

    signal_debounce #(.STABLE_CYCLES(1), .CNT_W(1), .RESET_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .signal(sig_b),
        .level(level_b), .rise(rise_b), .fall(fall_b), .busy(busy_b));

    signal_debounce #(.STABLE_CYCLES(16), .CNT_W(5), .RESET_LEVEL(1'b1)) dut_c (
        .clk(clk), .reset(reset_c), .signal(sig_c),
        .level(level_c), .rise(rise_c), .fall(fall_c), .busy(busy_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_a = 1'b0; sig_a = 1'b1;
        reset_b = 1'b0; sig_b = 1'b0;
        reset_c = 1'b0; sig_c = 1'b1;

        // Rise with defaults: reset held with signal high
        repeat (3) tick();
        check("a_rst_level", level_a, 1'b0);
        check("a_rst_rise",  rise_a,  1'b0);
        check("a_rst_fall",  fall_a,  1'b0);
        check("a_rst_busy",  busy_a,  1'b0);
        reset_a = 1'b1;
        tick();                                     // E0
        check("a_e0_busy", busy_a, 1'b0);
        tick();                                     // E1
        check("a_e1_busy", busy_a, 1'b0);
        tick();                                     // E2
        check("a_e2_busy",  busy_a,  1'b1);
        check("a_e2_level", level_a, 1'b0);
        repeat (14) tick();                         // E16
        check("a_e16_level", level_a, 1'b0);
        check("a_e16_rise",  rise_a,  1'b0);
        check("a_e16_busy",  busy_a,  1'b1);
        tick();                                     // E17
        check("a_e17_level", level_a, 1'b1);
        check("a_e17_rise",  rise_a,  1'b1);
        check("a_e17_fall",  fall_a,  1'b0);
        check("a_e17_busy",  busy_a,  1'b0);
        tick();                                     // E18
        check("a_e18_rise",  rise_a,  1'b0);
        check("a_e18_level", level_a, 1'b1);

        // Fall from level 1
        sig_a = 1'b0;
        repeat (17) tick();                         // E16
        check("fall_e16_fall",  fall_a,  1'b0);
        check("fall_e16_level", level_a, 1'b1);
        tick();                                     // E17
        check("fall_e17_fall",  fall_a,  1'b1);
        check("fall_e17_level", level_a, 1'b0);
        check("fall_e17_rise",  rise_a,  1'b0);
        tick();                                     // E18
        check("fall_e18_fall",  fall_a,  1'b0);
        check("fall_e18_rise",  rise_a,  1'b0);

        // Glitch of 10 cycles is rejected
        sig_a = 1'b1;
        for (int i = 0; i < 10; i++) begin          // E0..E9
            tick();
            check("glitch_level", level_a, 1'b0);
            check("glitch_rise",  rise_a,  1'b0);
            check("glitch_fall",  fall_a,  1'b0);
        end
        check("glitch_e9_busy", busy_a, 1'b1);
        sig_a = 1'b0;
        tick();                                     // E10
        check("glitch_e10_busy", busy_a, 1'b1);
        tick();                                     // E11: count still advances on the stale sync1
        check("glitch_e11_busy", busy_a, 1'b1);
        tick();                                     // E12
        check("glitch_e12_busy",  busy_a,  1'b0);
        check("glitch_e12_level", level_a, 1'b0);
        check("glitch_e12_rise",  rise_a,  1'b0);
        check("glitch_e12_fall",  fall_a,  1'b0);

        // Reset in the middle of a rise count at count = 8
        sig_a = 1'b1;
        repeat (10) tick();                         // E9, count = 8
        check("midrst_pre_busy", busy_a, 1'b1);
        reset_a = 1'b0;
        #1;
        check("midrst_level", level_a, 1'b0);
        check("midrst_busy",  busy_a,  1'b0);
        check("midrst_rise",  rise_a,  1'b0);
        tick();
        tick();
        check("midrst_held_busy", busy_a, 1'b0);
        check("midrst_held_rise", rise_a, 1'b0);
        reset_a = 1'b1;
        repeat (17) tick();                         // E16 after release
        check("midrst_e16_rise",  rise_a,  1'b0);
        check("midrst_e16_level", level_a, 1'b0);
        tick();                                     // E17
        check("midrst_e17_rise",  rise_a,  1'b1);
        check("midrst_e17_level", level_a, 1'b1);

        // STABLE_CYCLES = 1: toggle every cycle, level is signal delayed by two edges
        check("b_rst_level", level_b, 1'b0);
        reset_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sig_b = logic'(k % 2 == 0);
            tick();                                 // edge k
            check("b_level", level_b, logic'(k >= 2 && k % 2 == 0));
            check("b_rise",  rise_b,  logic'(k >= 2 && k % 2 == 0));
            check("b_fall",  fall_b,  logic'(k >= 3 && k % 2 == 1));
            check("b_coincident", rise_b & fall_b, 1'b0);
        end

        // RESET_LEVEL = 1 with signal held high
        check("c_rst_level", level_c, 1'b1);
        check("c_rst_busy",  busy_c,  1'b0);
        reset_c = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("c_level", level_c, 1'b1);
            check("c_rise",  rise_c,  1'b0);
            check("c_fall",  fall_c,  1'b0);
            check("c_busy",  busy_c,  1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/signal_debounce.md
# signal_debounce

Conditions one raw asynchronous input, such as a push button, sensor line or cross-domain strobe, into the design clock domain. It produces a glitch-free level plus single-cycle rise and fall pulses. The block is the consuming end of the delay chain. The input passes through a 2-flop synchronizer, then a stability counter that accepts a new level only after it has held for a programmable number of cycles. It sits between pad or foreign-domain signals and all control FSMs that need clean edges.

## Interface
- STABLE_CYCLES, 16: consecutive mismatching clock edges required before `level` changes; legal range is ≥ 1.
- CNT_W, 5: counter width; must satisfy 2^CNT_W ≥ STABLE_CYCLES.
- RESET_LEVEL, 0: value loaded into the synchronizer flops and `level` on reset.
- clk  in  1  single design clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- signal  in  1  raw asynchronous input.
- level  out  1  debounced, synchronized level (registered).
- rise  out  1  one-cycle pulse on the cycle `level` goes 0→1 (registered).
- fall  out  1  one-cycle pulse on the cycle `level` goes 1→0 (registered).
- busy  out  1  high while a candidate change is being counted (count ≠ 0).

## Operation
- Synchronizer: on each edge, `sync0 <= signal` and `sync1 <= sync0`. Only `sync1` feeds the logic.
- States: STABLE (count = 0, sync1 = level) and COUNT (count > 0).
- On each edge where sync1 ≠ level:
  - If count = STABLE_CYCLES−1: `level <= sync1`, count <= 0, and `rise` or `fall` <= 1 according to the new level.
  - Otherwise count <= count+1, entering or staying in COUNT.
- On each edge where sync1 = level: count <= 0 and the state returns to STABLE. This rejects glitches; the partial count is discarded, not held.
- `rise` and `fall` are 0 on every edge other than the update edge. They are never both high.
- Count never exceeds STABLE_CYCLES−1; there is no wrap.
- `busy` = (count ≠ 0), combinational from the count register.
- STABLE_CYCLES = 1 degenerates to a pure 2-edge delay of `signal`. Pulses are still generated.

## Timing
- Reset value (reset = 0, asynchronous, immediate):
  - sync0, sync1 and level take RESET_LEVEL.
  - count = 0, rise = 0, fall = 0, busy = 0.
- Reset release: the block operates from the first rising edge with reset = 1. No pulse is generated for a RESET_LEVEL mismatch at release; it is counted like any other change.
- Latency: `signal` changes and stays stable before edge E0.
  - sync0 updates at E0 and sync1 at E1.
  - The first mismatch edge is E2.
  - `level` and the pulse update at edge E(STABLE_CYCLES+1).
  - The default is E17.
- A pulse is high for exactly the one cycle following the update edge.
- An input change back to the current level at any point during COUNT clears the count on the next edge that sees it in sync1. No output changes.
- A new change after an update starts a fresh count; the minimum spacing of consecutive pulses is STABLE_CYCLES edges.
- Reset asserted mid-count aborts the count immediately. No pulse is produced, and a full count restarts after release.

## Test plan
- Rise, defaults: reset low with signal = 1, then release; hold signal = 1. Required:
  - All outputs are 0 during reset.
  - `busy` rises at E2.
  - `level` = 1 and `rise` = 1 for one cycle at E17; `fall` stays 0.
- Glitch reject: from level = 0, drive signal = 1 for 10 cycles, then 0. Required: level stays 0, no rise or fall, and busy returns to 0 two edges after the input drops.
- Fall: from level = 1, drive signal = 0 stably. Required: `fall` pulses for exactly one cycle at E17, level = 0, and `rise` stays 0.
- Mid-count reset: during a rise count at count = 8, pull reset low for 2 cycles, then release with signal = 1 held. Required:
  - level, count and busy clear immediately, with no pulse.
  - `rise` arrives 17 edges after the first post-release edge.
- STABLE_CYCLES = 1: toggle `signal` every cycle. Required: `level` equals `signal` delayed by 2 edges, and `rise` and `fall` alternate each cycle, never coincident.
- RESET_LEVEL = 1: hold signal = 1 through reset and release. Required: level = 1 from reset, with no rise, fall or busy at any time.
